// File: rtl/inst_feeder_pkg.sv
// inst_feeder_pkg: shared state encoding and instruction constants for the feeder
package inst_feeder_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;
  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] OP_ADDI = 6'b010000;
endpackage

// File: rtl/inst_feeder_if.sv
// inst_feeder_if: loader write port and cpu issue port of the feeder (issue_count with INST_FEEDER_ISSUE_CNT_EN)
interface inst_feeder_if #(parameter int INST_W = 32, parameter int ADDR_W = 4);
  logic              load_valid;
  logic [INST_W-1:0] load_data;
  logic              load_ready;
  logic              start;
  logic              clear;
  logic              loop_en;
  logic [INST_W-1:0] inst_out;
  logic              inst_valid;
  logic              inst_ready;
  logic [ADDR_W-1:0] pc_out;
  logic [ADDR_W:0]   count;
  logic              busy;
  logic              done;
`ifdef INST_FEEDER_ISSUE_CNT_EN
  logic [15:0]       issue_count;
`endif
  modport master (
    output load_valid, load_data, start, clear, loop_en, inst_ready,
    input  load_ready, inst_out, inst_valid, pc_out, count, busy, done
`ifdef INST_FEEDER_ISSUE_CNT_EN
    , input issue_count
`endif
  );
  modport slave (
    input  load_valid, load_data, start, clear, loop_en, inst_ready,
    output load_ready, inst_out, inst_valid, pc_out, count, busy, done
`ifdef INST_FEEDER_ISSUE_CNT_EN
    , output issue_count
`endif
  );
endinterface

// File: rtl/inst_feeder_mem.sv
// inst_feeder_mem: program buffer with synchronous write and asynchronous read
module inst_feeder_mem #(
  parameter int INST_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [INST_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [INST_W-1:0] rdata_o
);
  logic [INST_W-1:0] mem_q [2**ADDR_W];
  always_ff @(posedge clk)
    if (we_i) mem_q[waddr_i] <= wdata_i;
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/inst_feeder.sv
// inst_feeder: loads a program then replays it to the cpu with stall/loop/replay; INST_FEEDER_ISSUE_CNT_EN adds issue_count
module inst_feeder
  import inst_feeder_pkg::*;
#(
  parameter int INST_W = 32,
  parameter int ADDR_W = 4,
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(NOP_DEFAULT)
) (
  input logic         clk,
  input logic         rst_n,
  inst_feeder_if.slave bus
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [INST_W-1:0] rd_data;
  logic              we, last;
  // count never exceeds DEPTH, so its MSB alone flags a full buffer
  assign bus.load_ready = state_q == IDLE && !count_q[ADDR_W];
  assign we = bus.load_valid && bus.load_ready && !bus.clear;
  assign last = {1'b0, rd_ptr_q} + (ADDR_W+1)'(1) == count_q;
  inst_feeder_mem #(.INST_W(INST_W), .ADDR_W(ADDR_W)) u_mem (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.load_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.clear) begin
      state_d  = IDLE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          wr_ptr_d = wr_ptr_q + ADDR_W'(we);
          count_d  = count_q + (ADDR_W+1)'(we);
          if (bus.start && count_d != '0) begin
            state_d  = RUN;
            rd_ptr_d = '0;
          end
        end
        RUN: if (bus.inst_ready) begin
          rd_ptr_d = last ? '0 : rd_ptr_q + ADDR_W'(1);
          state_d  = last && !bus.loop_en ? DONE : RUN;
        end
        DONE: if (bus.start) begin
          state_d  = RUN;
          rd_ptr_d = '0;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
  assign bus.inst_valid = state_q == RUN;
  assign bus.inst_out   = bus.inst_valid ? rd_data : NOP_INST;
  assign bus.pc_out     = rd_ptr_q;
  assign bus.count      = count_q;
  assign bus.busy       = state_q == RUN;
  assign bus.done       = state_q == DONE;
`ifdef INST_FEEDER_ISSUE_CNT_EN
  logic [15:0] issue_q, issue_d;
  assign issue_d = (bus.clear || (state_q != RUN && bus.start)) ? '0 :
                   (bus.inst_valid && bus.inst_ready && issue_q != 16'hFFFF) ? issue_q + 16'd1 : issue_q;
  always_ff @(posedge clk) begin
    if (!rst_n) issue_q <= '0;
    else issue_q <= issue_d;
  end
  assign bus.issue_count = issue_q;
`endif
endmodule

// File: doc/inst_feeder.md
Name: inst_feeder

Overview:
- Parametrised instruction sequencer that replaces hand-timed instruction driving of the cpu `Inst` input.
- A program is loaded through a valid/ready write port into an internal buffer of DEPTH words.
- After `start`, the buffer is replayed to the cpu one instruction per accepted handshake, with stall, loop and replay modes.
- Sits between the bench/loader and the cpu instruction input; also usable as a boot ROM shim.

Parameters:
- INST_W, 32, instruction width in bits.
- ADDR_W, 4, buffer address width; DEPTH = 2**ADDR_W (16 words).
- NOP_INST, 32'h0000_0000, value driven on `inst_out` whenever not issuing (sll $0,$0,0).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- load_valid  in  1  loader presents `load_data`.
- load_data  in  INST_W  instruction word to append.
- load_ready  out  1  buffer accepts a word this cycle.
- start  in  1  one-cycle pulse: begin or replay issue from address 0.
- clear  in  1  empty the buffer and return to IDLE.
- loop_en  in  1  wrap to address 0 after the last word instead of finishing.
- inst_out  out  INST_W  instruction to cpu.
- inst_valid  out  1  `inst_out` is a program instruction.
- inst_ready  in  1  cpu consumes `inst_out` this cycle; low = stall.
- pc_out  out  ADDR_W  buffer index of `inst_out`.
- count  out  ADDR_W+1  number of words loaded (0..DEPTH).
- busy  out  1  state == RUN.
- done  out  1  state == DONE.

Behaviour:
- Reset (rst_n low at a clk edge): state=IDLE, count=0, wr_ptr=0, rd_ptr=0, inst_out=NOP_INST, inst_valid=0, pc_out=0, busy=0, done=0. Buffer contents are not reset.
- Reset mid-RUN aborts issue immediately; the next cycle shows reset values.
- IDLE:
  - load_ready = (count < DEPTH).
  - On load_valid&&load_ready: mem[wr_ptr]<=load_data, wr_ptr++, count++.
  - When full, load_ready=0 and load_valid is ignored; no overwrite, no wrap.
  - start with count>0: rd_ptr<=0, go RUN.
  - start with count==0: ignored, stay IDLE.
  - start and load_valid in the same cycle: the load is accepted and start uses the updated count.
- RUN:
  - load_ready=0.
  - Registered output: the cycle after start, inst_out=mem[0], inst_valid=1, pc_out=0.
  - On inst_ready: advance to the next word, visible the following cycle. No bubbles while inst_ready stays high, giving 1 instruction/cycle.
  - inst_ready low: inst_out and pc_out hold stable.
  - Last word (rd_ptr==count-1) accepted:
    - loop_en=1: next word is mem[0], stay RUN. loop_en is sampled at the acceptance edge.
    - loop_en=0: go DONE, inst_valid=0, inst_out=NOP_INST.
  - start in RUN is ignored.
- DONE:
  - done=1, load_ready=0.
  - start replays from address 0 (back to RUN with identical timing); buffer is retained.
- clear, any state:
  - Next cycle state=IDLE, count=0, wr_ptr=0, inst_valid=0, inst_out=NOP_INST.
  - clear has priority over start and load.
- Pointer arithmetic is modulo DEPTH. count is ADDR_W+1 bits so that DEPTH is representable.

Optional Feature:
- Macro: INST_FEEDER_ISSUE_CNT_EN.
- When defined:
  - Extra output port issue_count, 16 bits.
  - Increments on every inst_valid&&inst_ready and saturates at 16'hFFFF.
  - Cleared by reset, clear and start.
- When undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package inst_feeder_pkg:
  - State encoding IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Default NOP constant.
  - Opcode/funct constants for the test encodings (ADD funct 6'b100000, ADDI opcode 6'b010000).
- Sub-module inst_feeder_mem:
  - DEPTH x INST_W array with synchronous write and asynchronous read.
  - Parameters INST_W, ADDR_W.
- The FSM and pointers stay in the top module.

Test Plan:
- Load 0x00000820, 0x40010001, 0x00210820, then start with inst_ready=1 and loop_en=0:
  - inst_out is 0x00000820, 0x40010001, 0x00210820 on three consecutive cycles, pc_out 0,1,2.
  - done=1 on the next cycle with inst_out=0x00000000.
- Same program, inst_ready low for 3 cycles while pc_out=1:
  - 0x40010001 is held for 4 cycles, then 0x00210820 follows.
  - Total of 3 instructions issued.
- Load 16 words, then drive load_valid again:
  - load_ready=0, count=16, and the 17th word is not written (replay shows the original mem[0..15]).
- loop_en=1 with a 3-word program:
  - pc_out sequence 0,1,2,0,1,2 without a bubble; done stays 0.
  - Deassert loop_en before pc_out=2 is accepted: DONE follows after that word.
- rst_n low for 1 cycle while pc_out=1 in RUN:
  - Next cycle state IDLE, inst_valid=0, count=0.
  - start with count==0 is then ignored.
- DONE followed by start:
  - Identical replay from pc_out=0.
  - With INST_FEEDER_ISSUE_CNT_EN, issue_count reads 3 after each pass.
